// File: rtl/ac_out_collector.sv
// AC column output collector: requantize, pack and buffer accumulator results.
// Words drain over valid/ready; FIFO overflow drops the word and sets a sticky flag.
module ac_out_collector #(
  parameter int ACC_WIDTH  = 35,
  parameter int OUT_WIDTH  = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ACC_WIDTH-1:0]      data_in,
  input  logic                      data_in_en,
  input  logic [5:0]                shift_amt,
  input  logic                      flush,
  output logic [PACK*OUT_WIDTH-1:0] out_data,
  output logic [PACK-1:0]           out_byte_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      almost_full,
  output logic                      overflow_err,
  output logic [15:0]               sat_count
);

  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = PACK * OUT_WIDTH;
  localparam int AW = ACC_WIDTH + 1;

  localparam logic [5:0] SMAX = 6'(ACC_WIDTH - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  localparam logic [OUT_WIDTH-1:0] MAXQ = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MINQ = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] cap_data;
  logic                 cap_en;
  logic [5:0]           cap_shift;
  logic                 cap_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data  <= '0;
      cap_en    <= 1'b0;
      cap_shift <= '0;
      cap_flush <= 1'b0;
    end else begin
      cap_data  <= data_in;
      cap_en    <= data_in_en;
      cap_shift <= (shift_amt > SMAX) ? SMAX : shift_amt;
      cap_flush <= flush;
    end
  end

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shr;
  logic [OUT_WIDTH-1:0] q;
  logic                 clip;

  // One extra bit of headroom keeps the round-half-up add from wrapping
  always_comb begin
    ext = {cap_data[ACC_WIDTH-1], cap_data};
    rnd = '0;
    if (cap_shift != 6'd0)
      rnd = AW'(1) << (cap_shift - 6'd1);
    sum  = ext + rnd;
    shr  = sum >>> cap_shift;
    q    = shr[OUT_WIDTH-1:0];
    clip = 1'b0;
    if (shr > MAXV) begin
      q    = MAXQ;
      clip = 1'b1;
    end else if (shr < MINV) begin
      q    = MINQ;
      clip = 1'b1;
    end
  end

  logic [WW-1:0]   pack_q;
  logic [PACK-1:0] mask_q;
  logic [LW-1:0]   lane_idx;
  logic [WW-1:0]   wr_word;
  logic [PACK-1:0] wr_mask;
  logic            last;
  logic            push;

  always_comb begin
    wr_word = pack_q;
    wr_mask = mask_q;
    last    = 1'b0;
    if (cap_en) begin
      wr_word[lane_idx*OUT_WIDTH +: OUT_WIDTH] = q;
      wr_mask[lane_idx] = 1'b1;
      last = (lane_idx == LW'(PACK - 1));
    end
    push = last | (cap_flush & (|wr_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q    <= '0;
      mask_q    <= '0;
      lane_idx  <= '0;
      sat_count <= '0;
    end else begin
      if (push) begin
        pack_q   <= '0;
        mask_q   <= '0;
        lane_idx <= '0;
      end else if (cap_en) begin
        pack_q   <= wr_word;
        mask_q   <= wr_mask;
        lane_idx <= lane_idx + 1'b1;
      end
      if (cap_en && clip && sat_count != 16'hFFFF)
        sat_count <= sat_count + 16'd1;
    end
  end

  logic [WW-1:0]   mem_d [FIFO_DEPTH];
  logic [PACK-1:0] mem_m [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            pop;
  logic            full;
  logic            wr_ok;

  assign pop   = (count != '0) & out_ready;
  assign full  = (count == CW'(FIFO_DEPTH));
  assign wr_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push & ~wr_ok)
        overflow_err <= 1'b1;
      count <= count + CW'(wr_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_d[wr_ptr] <= wr_word;
      mem_m[wr_ptr] <= wr_mask;
    end
  end

  assign out_valid   = (count != '0);
  assign out_data    = out_valid ? mem_d[rd_ptr] : '0;
  assign out_byte_en = out_valid ? mem_m[rd_ptr] : '0;
  assign almost_full = (count >= CW'(FIFO_DEPTH - 1));

endmodule

// File: doc/ac_out_collector.md
# ac_out_collector

Output collector that consumes the accumulator result stream (`data_out` / `data_out_en`) of one AC column. It requantizes each wide signed result to a narrow activation with a configurable right shift, rounding and saturation. It packs `PACK` activations per word and buffers the words in a small FIFO. Words are drained toward the output buffer over a valid/ready handshake. The AC stream cannot stall, so this block never backpressures its input; loss on FIFO overflow is flagged, never silent.

## Interface
- `ACC_WIDTH`, 35, width of incoming accumulator result (two's complement).
- `OUT_WIDTH`, 8, width of one packed activation (two's complement).
- `PACK`, 4, activations per output word; lane 0 in the LSBs.
- `FIFO_DEPTH`, 4, output word FIFO depth (power of two, ≥2).
- `clk` in 1 — single clock, all logic on posedge.
- `rst` in 1 — synchronous, active-high reset.
- `data_in` in ACC_WIDTH — accumulator result, signed.
- `data_in_en` in 1 — `data_in` valid this cycle; always accepted.
- `shift_amt` in 6 — right-shift amount, sampled with each accepted sample; values > ACC_WIDTH-1 are clamped to ACC_WIDTH-1.
- `flush` in 1 — one-cycle pulse; emit the partially filled word.
- `out_data` out PACK*OUT_WIDTH — FIFO head word.
- `out_byte_en` out PACK — per-lane valid mask of head word.
- `out_valid` out 1 — FIFO non-empty.
- `out_ready` in 1 — consumer accepts head when `out_valid & out_ready`.
- `almost_full` out 1 — FIFO occupancy ≥ FIFO_DEPTH-1.
- `overflow_err` out 1 — sticky; a word was dropped on a full FIFO.
- `sat_count` out 16 — saturating count of clipped samples.

## Operation
- Stage 0 (capture): on each edge, register `data_in`, `data_in_en`, clamped `shift_amt` and `flush` into the capture registers.
- Stage 1 (quantize + pack): quantization applies when the captured valid bit is high.
  - Shift `s`: arithmetic right shift by `s`. When `s > 0`, first add `1 << (s-1)` (round half up), with the sum computed at ACC_WIDTH+1 bits.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Each clipped sample increments `sat_count`, which holds at 16'hFFFF.
  - Write the result into lane `lane_idx` of the pack register. Set that lane's mask bit. Advance `lane_idx` (0..PACK-1, wraps to 0).
- Push condition: the word (including any lane written this cycle) is pushed when either of these holds:
  - the lane just written is PACK-1;
  - a captured flush is present and the mask is non-zero after this cycle's write.
- On push, the pack register, mask and `lane_idx` clear to 0 on the same edge.
- Flush with an empty mask and no concurrent sample is a no-op; no word is pushed.
- A flush concurrent with a sample is processed after that sample's lane write.
- FIFO behaviour:
  - Push when full with no simultaneous pop: the word is dropped, `overflow_err` is set, and the pack state still clears.
  - Push and pop in the same cycle when full: both succeed.
  - Pop on empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH; the count is held separately (0..FIFO_DEPTH).
- Reset mid-operation discards captured data, the partial word and all FIFO contents.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_byte_en`=0, `almost_full`=0, `overflow_err`=0, `sat_count`=0; `lane_idx`, mask, capture registers and FIFO pointers/count are 0.
- Latency: a sample presented in cycle t is captured at edge t+1 and written to its lane at edge t+2.
  - If that sample completes a word, the word is pushed at edge t+2, and `out_valid` is high in cycle t+2 when the FIFO was empty.
  - Total: 2 cycles from the PACK-th sample to `out_valid`.
- Flush has the same 2-cycle latency as a sample.
- `out_data` and `out_byte_en` are FIFO-registered and stable while `out_valid & ~out_ready`.
- Throughput: one sample per cycle indefinitely while `out_ready` stays high.

## Test plan
- Rounding and packing: `shift_amt`=4; samples 16, 24, -24, 7.
  - Required: one word with lanes 1, 2, -1, 0 → `out_data`=32'h00FF0201, `out_byte_en`=4'hF, `out_valid` 2 cycles after the 4th sample.
- Saturation: `shift_amt`=0; samples 200, -300, 127, -128.
  - Required: `out_data`=32'h807F807F, `sat_count`=2.
- Flush handling: samples 5, 6 with `shift_amt`=0, then `flush` 3 cycles later.
  - Required: `out_data`=32'h00000605, `out_byte_en`=4'h3, `lane_idx` back at 0.
  - A second flush with nothing pending: no push.
- Flush together with the 3rd sample (samples 1, 2, 3).
  - Required: a single word with `out_byte_en`=4'h7 and lanes 1, 2, 3.
- Backpressure and overflow: `out_ready`=0, stream 20 samples.
  - Required: FIFO holds 4 words, `almost_full` asserts after the 3rd push, the 5th word is dropped, and `overflow_err`=1 stays set.
  - Then raise `out_ready`: the 4 words drain in order.
  - Full-FIFO push and pop in the same cycle: no drop.
- Reset mid-word: after 2 samples, pulse `rst`.
  - Required: all outputs return to their reset values, and the next 4 samples form a clean word starting at lane 0.
